// File: rtl/bnn_frame_loader_if.sv
// Byte-stream handshake between the chip I/O byte port and the frame loader.
interface bnn_frame_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bnn_frame_loader.sv
// Byte-serial loader for the binarized conv layer: assembles IC image planes
// and OC packed 3x3xIC weight words, then holds them stable until released.
module bnn_frame_loader #(
  parameter int IC          = 4,
  parameter int OC          = 8,
  parameter int IMG_IN_SIZE = 30
) (
  input  logic                                 clk,
  input  logic                                 rst,
  bnn_frame_loader_if.slave                    bus,
  input  logic                                 keep_weights,
  input  logic                                 frame_consumed,
  input  logic                                 data_out_ready,
  output logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in  [0:IC-1],
  output logic [IC*9-1:0]                      weights [0:OC-1],
  output logic                                 data_in_ready,
  output logic                                 conv_done
);

  localparam int PLANE_W   = IMG_IN_SIZE * IMG_IN_SIZE;
  localparam int W_W       = IC * 9;
  localparam int IMG_BYTES = (PLANE_W + 7) / 8;
  localparam int W_BYTES   = (W_W + 7) / 8;
  localparam int MAX_BYTES = (IMG_BYTES > W_BYTES) ? IMG_BYTES : W_BYTES;
  localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int MAX_IDX   = (IC > OC) ? IC : OC;
  localparam int IDX_W     = (MAX_IDX > 1) ? $clog2(MAX_IDX) : 1;

  typedef enum logic [1:0] {
    LOAD_IMG,
    LOAD_W,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt;
  logic [IDX_W-1:0] idx;
  logic             img_only;
  logic             accept;
  logic             last_byte;
  logic             last_idx;
  logic [CNT_W+2:0] bit_ofs;
  logic [PLANE_W-1:0] img_data, img_mask;
  logic [W_W-1:0]     w_data, w_mask;

  assign bus.in_ready  = (state_q != HOLD);
  assign data_in_ready = (state_q == HOLD);
  assign accept        = bus.in_valid && (state_q != HOLD);

  assign last_byte = (state_q == LOAD_IMG) ? (byte_cnt == CNT_W'(IMG_BYTES - 1))
                                           : (byte_cnt == CNT_W'(W_BYTES - 1));
  assign last_idx  = (state_q == LOAD_IMG) ? (idx == IDX_W'(IC - 1))
                                           : (idx == IDX_W'(OC - 1));

  // Byte k lands on bits [8k+7:8k]; shifting a full-width mask drops any bits
  // past the destination width, so a partial last byte never spills over.
  assign bit_ofs  = {byte_cnt, 3'b000};
  assign img_data = PLANE_W'(bus.in_data) << bit_ofs;
  assign img_mask = PLANE_W'(8'hFF) << bit_ofs;
  assign w_data   = W_W'(bus.in_data) << bit_ofs;
  assign w_mask   = W_W'(8'hFF) << bit_ofs;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= LOAD_IMG;
    else     state_q <= state_d;
  end

  // Next-state logic: image section, optional weight section, then hold.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      LOAD_IMG: if (accept && last_byte && last_idx) state_d = img_only ? HOLD : LOAD_W;
      LOAD_W:   if (accept && last_byte && last_idx) state_d = HOLD;
      HOLD:     if (frame_consumed)                  state_d = LOAD_IMG;
      default:  state_d = LOAD_IMG;
    endcase
  end

  // Byte / plane-word counters and the image-only flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      idx      <= '0;
      img_only <= 1'b0;
    end else if (state_q == HOLD) begin
      if (frame_consumed) begin
        byte_cnt <= '0;
        idx      <= '0;
        img_only <= keep_weights;
      end
    end else if (accept) begin
      if (last_byte) begin
        byte_cnt <= '0;
        idx      <= last_idx ? '0 : idx + 1'b1;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Operand registers: merge the accepted byte into the addressed plane/word.
  always_ff @(posedge clk) begin
    // NOTE: operand storage is flops, not RAM, and the outputs must read zero
    // after reset, so every array entry is cleared explicitly.
    if (rst) begin
      for (int p = 0; p < IC; p++) img_in[p] <= '0;
      for (int o = 0; o < OC; o++) weights[o] <= '0;
    end else if (accept) begin
      if (state_q == LOAD_IMG) begin
        for (int p = 0; p < IC; p++)
          if (idx == IDX_W'(p)) img_in[p] <= (img_in[p] & ~img_mask) | (img_data & img_mask);
      end else begin
        for (int o = 0; o < OC; o++)
          if (idx == IDX_W'(o)) weights[o] <= (weights[o] & ~w_mask) | (w_data & w_mask);
      end
    end
  end

  // Registered completion status for the consumer.
  always_ff @(posedge clk) begin
    if (rst) conv_done <= 1'b0;
    else     conv_done <= data_out_ready & data_in_ready;
  end

endmodule

// File: doc/bnn_frame_loader.md
# bnn_frame_loader

Byte-serial input loader for the binarized 2D convolution layer. It assembles `IC` binary image planes and `OC` packed 3x3xIC weight words from an 8-bit valid/ready stream. It then raises `data_in_ready` and holds the operands stable until the downstream consumer releases the frame. It sits between the chip I/O byte interface and the conv layer's `img_in`/`weights`/`data_in_ready` inputs, and also observes that layer's `data_out_ready`.

## Interface
- `IC`, default 4: input channels (image planes).
- `OC`, default 8: output channels (weight words).
- `IMG_IN_SIZE`, default 30: plane edge length; plane width is `IMG_IN_SIZE*IMG_IN_SIZE` bits.
- Derived `IMG_BYTES = ceil(IMG_IN_SIZE^2/8)`, default 113.
- Derived `W_BYTES = ceil(IC*9/8)`, default 5.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `keep_weights`  in  1  sampled with `frame_consumed`; when 1, the next frame loads image planes only.
- `frame_consumed`  in  1  single-cycle pulse from the consumer: the results have been read, release the operands.
- `data_out_ready`  in  1  the conv layer's done flag; only drives the `conv_done` status output.
- `img_in[0:IC-1]`  out  `IMG_IN_SIZE^2` each  image planes.
- `weights[0:OC-1]`  out  `IC*9` each  weight words.
- `data_in_ready`  out  1  operands complete and stable.
- `conv_done`  out  1  registered `data_out_ready & data_in_ready`.

## Operation
- States: `LOAD_IMG`, `LOAD_W`, `HOLD`.
- Reset state is `LOAD_IMG`, with the plane/word index and the byte counter at 0.
- Byte acceptance: a byte is accepted when `in_valid & in_ready`. `in_ready` is 1 in `LOAD_IMG`/`LOAD_W` and 0 in `HOLD`.
- Stream order:
  - plane 0 bytes 0..IMG_BYTES-1, then plane 1, and so on up to plane IC-1;
  - then weight word 0 bytes 0..W_BYTES-1, up to word OC-1.
- Bit packing is LSB-first. Byte k of a plane/word writes bits `[8k+7:8k]` of the destination.
  - Bits at or above the destination width are discarded and never spill into the next plane or word.
  - Destination bits not yet written keep their previous value.
- Transitions:
  - Last byte of plane IC-1 accepted → `LOAD_W`, or `HOLD` if the image-only flag is set.
  - Last byte of word OC-1 accepted → `HOLD`.
  - `HOLD` with `frame_consumed` = 1 → `LOAD_IMG`. Counters clear. The image-only flag latches `keep_weights`.
- `frame_consumed` is ignored outside `HOLD`.
- The image-only flag is cleared by reset, so the first frame after reset always loads weights.
- Registers are never cleared between frames; a new frame overwrites them byte by byte.

## Timing
- Reset values:
  - `in_ready` = 1;
  - `data_in_ready` = 0;
  - `conv_done` = 0;
  - all `img_in` and `weights` bits = 0.
- Write latency: a byte accepted at edge N is visible on `img_in`/`weights` after edge N.
- `data_in_ready` rises on the cycle after the final byte is accepted. It stays high, with all operand outputs frozen, for the whole of `HOLD`.
- `frame_consumed` at edge M: `data_in_ready` = 0 and `in_ready` = 1 from cycle M+1. This guarantees at least one low cycle on `data_in_ready`, which resets the conv layer.
- In `HOLD`, `in_valid` with `in_ready` = 0 is a stall and nothing is consumed.
- `rst` mid-load or mid-`HOLD`: on the next edge all outputs return to their reset values and the partial frame is discarded. `rst` takes priority over a simultaneous byte or `frame_consumed`.
- Throughput is one byte per cycle with no bubbles between planes, between words, or between the image and weight sections.
- Default full frame is 492 bytes; an image-only frame is 452 bytes.

## Test plan
- Reset, then stream 492 bytes where plane 0 byte 0 = 0xA5 and weight word 0 bytes = 01,00,00,00,08 → `img_in[0][7:0]` = 8'hA5 and `weights[0]` = 36'h800000001. `data_in_ready` is 1 exactly one cycle after byte 492.
- Plane 0 byte 112 = 0xFF and all plane 1 bytes = 0x00 → `img_in[0][899:896]` = 4'hF and `img_in[1]` = 0, so there is no spill.
- Random `in_valid` gaps (50% duty) on a full frame → operands identical to the gap-free run, and `in_ready` is never 0 before `HOLD`.
- In `HOLD`, drive `in_valid` = 1 for 20 cycles → outputs unchanged, `in_ready` = 0. Pulse `frame_consumed` with `keep_weights` = 1 → `data_in_ready` is 0 on the next cycle. After 452 bytes, `HOLD` is re-entered and `weights` still equals the previous frame's values.
- Assert `rst` after byte 200 → all outputs read zero on the next cycle. A subsequent full 492-byte frame loads correctly.
- Drive `data_out_ready` = 1 while in `HOLD` → `conv_done` = 1 one cycle later. After `frame_consumed`, `conv_done` = 0.
